keypad_scanner: RTL and testbench

//  Scans a 4x4 active-low launchpad key matrix, synchronises and debounces the column

---
 rtl/keypad_scanner.sv | 168 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low key matrix scanner: row drive, column synchroniser, per-scan key
// detection and a scan-rate debounce FSM producing a stable key code and enable.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV  = 4,
    parameter int unsigned DEB_SCANS = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] COL_in,
    output logic [3:0] ROW_out,
    output logic [3:0] B_out,
    output logic       EN_out,
    output logic       KEY_stb
);

    localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CW = $clog2(DEB_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEB_SCANS);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    logic [3:0]    col_m;
    logic [3:0]    col_s;
    logic [1:0]    row_idx;
    logic [DW-1:0] dwell;
    logic          found_acc;
    logic [3:0]    code_acc;
    state_t        state;
    logic [3:0]    cand;
    logic [CW-1:0] cnt;

    logic          sample;
    logic          scan_end;
    logic          row_hit;
    logic [1:0]    hit_col;
    logic          scan_found;
    logic [3:0]    scan_code;

    // Lowest-index column reading low; only meaningful when some column is low.
    function automatic logic [1:0] first_low(input logic [3:0] c);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!c[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    // Per-row sample point and the scan result as seen at the scan-end cycle.
    always_comb begin
        sample     = 1'b0;
        scan_end   = 1'b0;
        row_hit    = 1'b0;
        hit_col    = 2'd0;
        scan_found = 1'b0;
        scan_code  = 4'd0;
        sample     = (dwell == DWELL_LAST);
        scan_end   = sample && (row_idx == 2'd3);
        row_hit    = (col_s != 4'hF);
        hit_col    = first_low(col_s);
        scan_found = found_acc | row_hit;
        scan_code  = found_acc ? code_acc : {row_idx, hit_col};
    end

    // Two-flop synchroniser for the asynchronous column returns.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            col_m <= 4'hF;
            col_s <= 4'hF;
        end else begin
            col_m <= COL_in;
            col_s <= col_m;
        end
    end

    // Row rotation and first-hit capture across one full scan.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_idx   <= 2'd0;
            dwell     <= '0;
            ROW_out   <= 4'b1110;
            found_acc <= 1'b0;
            code_acc  <= 4'd0;
        end else if (sample) begin
            dwell   <= '0;
            row_idx <= row_idx + 2'd1;
            ROW_out <= ~(4'b0001 << (row_idx + 2'd1));
            if (scan_end) begin
                found_acc <= 1'b0;
                code_acc  <= 4'd0;
            end else if (!found_acc && row_hit) begin
                found_acc <= 1'b1;
                code_acc  <= {row_idx, hit_col};
            end
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    // Debounce FSM, advanced once per scan.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cand    <= 4'd0;
            cnt     <= '0;
            B_out   <= 4'd0;
            EN_out  <= 1'b0;
            KEY_stb <= 1'b0;
        end else begin
            KEY_stb <= 1'b0;
            if (scan_end) begin
                case (state)
                    IDLE: begin
                        if (scan_found) begin
                            state <= PRESS_CHK;
                            cand  <= scan_code;
                            cnt   <= CNT_ONE;
                        end
                    end
                    PRESS_CHK: begin
                        if (!scan_found) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (scan_code != cand) begin
                            cand <= scan_code;
                            cnt  <= CNT_ONE;
                        end else if ((cnt + CNT_ONE) == CNT_DONE) begin
                            state   <= HELD;
                            B_out   <= cand;
                            EN_out  <= 1'b1;
                            KEY_stb <= 1'b1;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    HELD: begin
                        if (!(scan_found && (scan_code == B_out))) begin
                            state <= REL_CHK;
                            cnt   <= CNT_ONE;
                        end
                    end
                    REL_CHK: begin
                        if (scan_found && (scan_code == B_out)) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if ((cnt + CNT_ONE) == CNT_DONE) begin
                            state  <= IDLE;
                            EN_out <= 1'b0;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical key-matrix model drives the columns and a
// scan-level streak model predicts row drive, key code, enable and strobe every cycle.
module tb_keypad_scanner;

    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 3;
    localparam int SCAN_LEN  = 4 * SCAN_DIV;
    localparam int BUDGET    = 6 * SCAN_LEN;

    logic        CLK;
    logic        RST;
    logic [3:0]  COL_in;
    logic [3:0]  ROW_out;
    logic [3:0]  B_out;
    logic        EN_out;
    logic        KEY_stb;

    logic [15:0] keys;
    int          total;
    int          bad;

    logic        model_on;
    int          cyc;
    logic [15:0] hist [4];
    logic [15:0] seen;
    logic        m_en;
    logic [3:0]  m_b;
    logic        m_stb;
    logic [3:0]  m_cand;
    int          streak;
    int          miss;
    int          stb_cnt;

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .COL_in  (COL_in),
        .ROW_out (ROW_out),
        .B_out   (B_out),
        .EN_out  (EN_out),
        .KEY_stb (KEY_stb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Pressed key (r,c) shorts row r to column c; columns are pulled high.
    always_comb begin
        COL_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !ROW_out[r]) COL_in[c] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        seen   = 16'h0;
        m_en   = 1'b0;
        m_b    = 4'h0;
        m_stb  = 1'b0;
        m_cand = 4'h0;
        streak = 0;
        miss   = 0;
    endtask

    // Effect of the clock edge that ends cycle k (keys reach the sampler 2 cycles late).
    task automatic model_step(input int k);
        int         r;
        logic [15:0] kh;
        logic       found;
        logic [3:0] code;
        m_stb = 1'b0;
        if ((k % SCAN_DIV) == SCAN_DIV - 1) begin
            r  = (k / SCAN_DIV) % 4;
            kh = hist[(k - 2) & 3];
            for (int c = 0; c < 4; c++) if (kh[r*4+c]) seen[r*4+c] = 1'b1;
        end
        if ((k % SCAN_LEN) == SCAN_LEN - 1) begin
            found = (seen != 16'h0);
            code  = 4'h0;
            for (int i = 15; i >= 0; i--) if (seen[i]) code = 4'(i);
            if (m_en) begin
                if (found && code == m_b) miss = 0;
                else begin
                    miss++;
                    if (miss == DEB_SCANS) begin
                        m_en   = 1'b0;
                        miss   = 0;
                        streak = 0;
                    end
                end
            end else begin
                if (!found) streak = 0;
                else if (streak > 0 && code == m_cand) streak++;
                else begin
                    m_cand = code;
                    streak = 1;
                end
                if (streak == DEB_SCANS) begin
                    m_en   = 1'b1;
                    m_b    = m_cand;
                    m_stb  = 1'b1;
                    streak = 0;
                    miss   = 0;
                end
            end
            seen = 16'h0;
        end
    endtask

    // Cycle monitor: advance the model and compare all outputs mid-cycle.
    initial begin
        logic [3:0] er;
        forever begin
            @(negedge CLK);
            if (model_on) begin
                if (cyc > 0) model_step(cyc - 1);
                hist[cyc & 3] = keys;
                er = ~(4'b0001 << ((cyc / SCAN_DIV) % 4));
                check("row", 32'(ROW_out), 32'(er));
                check("en", 32'(EN_out), 32'(m_en));
                check("b", 32'(B_out), 32'(m_b));
                check("stb", 32'(KEY_stb), 32'(m_stb));
                if (KEY_stb) stb_cnt++;
                cyc++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic restart();
        model_reset();
        cyc      = 0;
        model_on = 1'b1;
    endtask

    task automatic wait_en(input logic level, input string tag);
        int n;
        n = 0;
        while (EN_out !== level && n < BUDGET) begin
            @(negedge CLK);
            n++;
        end
        check(tag, 32'(EN_out), 32'(level));
        tick(1);
    endtask

    task automatic settle_release();
        keys = 16'h0;
        wait_en(1'b0, "release_fall");
        tick(SCAN_LEN);
    endtask

    initial begin
        int   s0;
        logic en_seen;
        logic en_low;
        total    = 0;
        bad      = 0;
        stb_cnt  = 0;
        model_on = 1'b0;
        cyc      = 0;
        keys     = 16'h0;
        model_reset();

        // Reset values while reset is held.
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_row", 32'(ROW_out), 32'hE);
        check("rst_b", 32'(B_out), 32'h0);
        check("rst_en", 32'(EN_out), 32'h0);
        check("rst_stb", 32'(KEY_stb), 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        restart();
        tick(2 * SCAN_LEN);

        // Single press (2,1).
        tick($urandom_range(0, SCAN_LEN - 1));
        s0   = stb_cnt;
        keys = 16'h1 << 9;
        wait_en(1'b1, "t2_rise");
        check("t2_code", 32'(B_out), 32'h9);
        tick(120);
        check("t2_one_stb", 32'(stb_cnt - s0), 32'd1);
        keys = 16'h0;
        wait_en(1'b0, "t2_fall");
        check("t2_code_kept", 32'(B_out), 32'h9);
        tick(SCAN_LEN);

        // Bounce on (0,0), then settle.
        tick($urandom_range(0, SCAN_LEN - 1));
        s0      = stb_cnt;
        en_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            keys[0] = ((i / 3) % 2) == 0;
            tick(1);
            if (EN_out) en_seen = 1'b1;
        end
        check("t3_quiet_en", 32'(en_seen), 32'd0);
        check("t3_quiet_stb", 32'(stb_cnt - s0), 32'd0);
        keys[0] = 1'b1;
        wait_en(1'b1, "t3_rise");
        check("t3_code", 32'(B_out), 32'h0);
        check("t3_one_stb", 32'(stb_cnt - s0), 32'd1);
        settle_release();

        // Two keys, then release the winning one.
        keys = (16'h1 << 7) | (16'h1 << 12);
        wait_en(1'b1, "t4_rise");
        check("t4_code_a", 32'(B_out), 32'h7);
        tick(40);
        s0   = stb_cnt;
        keys = 16'h1 << 12;
        wait_en(1'b0, "t4_drop");
        wait_en(1'b1, "t4_rerise");
        check("t4_code_b", 32'(B_out), 32'hC);
        check("t4_second_stb", 32'(stb_cnt - s0), 32'd1);
        settle_release();

        // One-scan dropout on (2,2) is absorbed.
        keys = 16'h1 << 10;
        wait_en(1'b1, "t5_rise");
        tick(20);
        s0     = stb_cnt;
        en_low = 1'b0;
        keys   = 16'h0;
        for (int i = 0; i < SCAN_LEN; i++) begin
            tick(1);
            if (!EN_out) en_low = 1'b1;
        end
        keys = 16'h1 << 10;
        for (int i = 0; i < 5 * SCAN_LEN; i++) begin
            tick(1);
            if (!EN_out) en_low = 1'b1;
        end
        check("t5_en_kept", 32'(en_low), 32'd0);
        check("t5_no_stb", 32'(stb_cnt - s0), 32'd0);
        settle_release();

        // Asynchronous reset pulse while (3,3) is held.
        keys = 16'h1 << 15;
        wait_en(1'b1, "t6_rise");
        check("t6_code", 32'(B_out), 32'hF);
        tick(10);
        @(posedge CLK);
        #2;
        model_on = 1'b0;
        RST      = 1'b1;
        #1;
        check("t6_rst_en", 32'(EN_out), 32'h0);
        check("t6_rst_b", 32'(B_out), 32'h0);
        check("t6_rst_row", 32'(ROW_out), 32'hE);
        check("t6_rst_stb", 32'(KEY_stb), 32'h0);
        RST = 1'b0;
        restart();
        s0 = stb_cnt;
        wait_en(1'b1, "t6_rerise");
        check("t6_recode", 32'(B_out), 32'hF);
        check("t6_stb", 32'(stb_cnt - s0), 32'd1);
        settle_release();

        // Random key sets, hold times and bounces against the model.
        for (int it = 0; it < 30; it++) begin
            logic [15:0] k;
            k = 16'h0;
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) k[$urandom_range(0, 15)] = 1'b1;
            keys = k;
            if ($urandom_range(0, 2) == 0) begin
                for (int j = 0; j < int'($urandom_range(2, 12)); j++) begin
                    keys = k ^ (16'h1 << $urandom_range(0, 15));
                    tick($urandom_range(1, 3));
                end
                keys = k;
            end
            tick($urandom_range(8, 100));
        end
        settle_release();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
